// File: rtl/fifo_param_if.sv
// rtl/fifo_param_if.sv - handshake and status bundle for fifo_param
interface fifo_param_if #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [FIFO_WIDTH-1:0] data_in;
    logic                  wr_en;
    logic                  rd_en;
    logic [FIFO_WIDTH-1:0] data_out;
    logic                  rd_valid;
    logic                  wr_ack;
    logic                  overflow;
    logic                  underflow;
    logic                  full;
    logic                  empty;
    logic                  almostfull;
    logic                  almostempty;
    logic [CW-1:0]         count;

    modport master (
        output data_in, wr_en, rd_en,
        input  data_out, rd_valid, wr_ack, overflow, underflow,
               full, empty, almostfull, almostempty, count
    );

    modport slave (
        input  data_in, wr_en, rd_en,
        output data_out, rd_valid, wr_ack, overflow, underflow,
               full, empty, almostfull, almostempty, count
    );
endinterface

// File: rtl/fifo_param.sv
// rtl/fifo_param.sv - synchronous FIFO with registered or fall-through read
module fifo_param #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_THRESH  = 7,
    parameter int AE_THRESH  = 1,
    parameter int FWFT       = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    fifo_param_if.slave   bus
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
    localparam logic [PW-1:0] LAST_P  = PW'(FIFO_DEPTH - 1);

    if (!(AE_THRESH >= 1 && AE_THRESH < AF_THRESH && AF_THRESH <= FIFO_DEPTH - 1)) begin : g_bad_params
        $error("fifo_param: thresholds must satisfy 1 <= AE_THRESH < AF_THRESH <= FIFO_DEPTH-1");
    end

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [FIFO_WIDTH-1:0] head;
    logic [FIFO_WIDTH-1:0] data_out_r;
    logic                  rd_valid_r;
    logic                  wr_ack_r;
    logic                  overflow_r;
    logic                  underflow_r;
    logic                  wr_accept;
    logic                  rd_accept;

    // Acceptance: a full FIFO still takes a write when a read frees a slot the same edge;
    // an empty FIFO never lets a write bypass straight to the read side.
    always_comb begin
        rd_accept = bus.rd_en && (count != '0);
        wr_accept = bus.wr_en && ((count != DEPTH_C) || bus.rd_en);
        head      = mem[rd_ptr];
    end

    // Storage is deliberately left out of reset; only the pointers define what is live.
    always_ff @(posedge clk) begin
        if (rst_n && wr_accept) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    // Pointers wrap explicitly at FIFO_DEPTH-1 so non-power-of-two depths work.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= (wr_ptr == LAST_P) ? '0 : wr_ptr + PW'(1);
            end
            if (rd_accept) begin
                rd_ptr <= (rd_ptr == LAST_P) ? '0 : rd_ptr + PW'(1);
            end
            if (wr_accept && !rd_accept) begin
                count <= count + CW'(1);
            end else if (rd_accept && !wr_accept) begin
                count <= count - CW'(1);
            end
        end
    end

    // One-cycle status pulses reporting what happened to last cycle's requests.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ack_r    <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            wr_ack_r    <= wr_accept;
            overflow_r  <= bus.wr_en && !wr_accept;
            underflow_r <= bus.rd_en && (count == '0);
        end
    end

    // Registered read path: capture the head word as it is popped, hold it otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out_r <= '0;
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= rd_accept;
            if (rd_accept) begin
                data_out_r <= head;
            end
        end
    end

    // Output selection and occupancy flags, all derived from count.
    always_comb begin
        bus.count       = count;
        bus.full        = (count == DEPTH_C);
        bus.empty       = (count == '0);
        bus.almostfull  = (count >= AF_C);
        bus.almostempty = (count <= AE_C) && (count != '0);
        bus.wr_ack      = wr_ack_r;
        bus.overflow    = overflow_r;
        bus.underflow   = underflow_r;
        if (FWFT != 0) begin
            bus.data_out = head;
            bus.rd_valid = (count != '0);
        end else begin
            bus.data_out = data_out_r;
            bus.rd_valid = rd_valid_r;
        end
    end
endmodule

// File: tb/tb_fifo_param.sv
// tb/tb_fifo_param.sv - randomized scoreboard bench for fifo_param
module tb_fifo_param;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fifo_param_if #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) a_if ();
    fifo_param_if #(.FIFO_WIDTH(16), .FIFO_DEPTH(5)) b_if ();

    fifo_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .AF_THRESH(7), .AE_THRESH(1), .FWFT(0))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
    fifo_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(5), .AF_THRESH(4), .AE_THRESH(1), .FWFT(1))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model A: depth 8, registered read
    int          qa[$];
    int          exp_rd_a[$];
    bit          ea_ack, ea_ovf, ea_unf, ea_valid;
    logic [15:0] last_a;

    always @(posedge clk) begin
        int  sz;
        bit  wa, ra;
        if (!rst_n) begin
            qa.delete(); exp_rd_a.delete();
            ea_ack = 0; ea_ovf = 0; ea_unf = 0; ea_valid = 0; last_a = 16'h0;
        end else begin
            sz = qa.size();
            ra = a_if.rd_en && sz > 0;
            wa = a_if.wr_en && (sz < 8 || (a_if.rd_en && sz == 8));
            ea_ack = wa; ea_ovf = a_if.wr_en && !wa; ea_unf = a_if.rd_en && sz == 0;
            ea_valid = ra;
            if (ra) begin
                last_a = 16'(qa.pop_front());
                exp_rd_a.push_back(int'(last_a));
            end
            if (wa) qa.push_back(int'(a_if.data_in));
        end
    end

    // Monitor A
    always @(negedge clk) begin
        int sz;
        if (mon_en) begin
            sz = qa.size();
            check("a_count", 32'(a_if.count), 32'(sz));
            check("a_full", 32'(a_if.full), 32'(sz == 8));
            check("a_empty", 32'(a_if.empty), 32'(sz == 0));
            check("a_almostfull", 32'(a_if.almostfull), 32'(sz >= 7));
            check("a_almostempty", 32'(a_if.almostempty), 32'(sz <= 1 && sz != 0));
            check("a_wr_ack", 32'(a_if.wr_ack), 32'(ea_ack));
            check("a_overflow", 32'(a_if.overflow), 32'(ea_ovf));
            check("a_underflow", 32'(a_if.underflow), 32'(ea_unf));
            check("a_rd_valid", 32'(a_if.rd_valid), 32'(ea_valid));
            if (a_if.rd_valid === 1'b1) begin
                if (exp_rd_a.size() == 0) check("a_unexpected_word", 32'(a_if.data_out), 32'hFFFF_FFFF);
                else check("a_data", 32'(a_if.data_out), 32'(exp_rd_a.pop_front()));
            end else begin
                check("a_data_hold", 32'(a_if.data_out), 32'(last_a));
            end
        end
    end

    // Reference model B: depth 5, fall-through read
    int qb[$];
    int popped_b;
    bit eb_ack, eb_ovf, eb_unf;

    always @(posedge clk) begin
        int sz;
        bit wa, ra;
        if (!rst_n) begin
            qb.delete(); eb_ack = 0; eb_ovf = 0; eb_unf = 0;
        end else begin
            sz = qb.size();
            ra = b_if.rd_en && sz > 0;
            wa = b_if.wr_en && (sz < 5 || (b_if.rd_en && sz == 5));
            eb_ack = wa; eb_ovf = b_if.wr_en && !wa; eb_unf = b_if.rd_en && sz == 0;
            if (ra) begin
                void'(qb.pop_front());
                popped_b++;
            end
            if (wa) qb.push_back(int'(b_if.data_in));
        end
    end

    // Monitor B
    always @(negedge clk) begin
        int sz;
        if (mon_en) begin
            sz = qb.size();
            check("b_count", 32'(b_if.count), 32'(sz));
            check("b_full", 32'(b_if.full), 32'(sz == 5));
            check("b_empty", 32'(b_if.empty), 32'(sz == 0));
            check("b_almostfull", 32'(b_if.almostfull), 32'(sz >= 4));
            check("b_almostempty", 32'(b_if.almostempty), 32'(sz <= 1 && sz != 0));
            check("b_wr_ack", 32'(b_if.wr_ack), 32'(eb_ack));
            check("b_overflow", 32'(b_if.overflow), 32'(eb_ovf));
            check("b_underflow", 32'(b_if.underflow), 32'(eb_unf));
            check("b_rd_valid", 32'(b_if.rd_valid), 32'(sz != 0));
            if (sz != 0) check("b_head", 32'(b_if.data_out), 32'(qb[0]));
        end
    end

    task automatic drv_a(input bit w, input bit r, input logic [15:0] d);
        @(posedge clk); #2;
        a_if.wr_en = w; a_if.rd_en = r; a_if.data_in = d;
    endtask

    task automatic drv_b(input bit w, input bit r, input logic [15:0] d);
        @(posedge clk); #2;
        b_if.wr_en = w; b_if.rd_en = r; b_if.data_in = d;
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #2;
        rst_n = 1'b0;
        repeat (n) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int wrote;
        rst_n = 1'b0;
        popped_b = 0;
        a_if.wr_en = 0; a_if.rd_en = 0; a_if.data_in = '0;
        b_if.wr_en = 0; b_if.rd_en = 0; b_if.data_in = '0;
        @(posedge clk); #1 mon_en = 1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Fill to full, then overflow attempt
        for (int i = 1; i <= 8; i++) drv_a(1, 0, 16'hA000 + 16'(i));
        drv_a(1, 0, 16'hBEEF);
        // Full with simultaneous read and write
        drv_a(1, 1, 16'hC000);
        drv_a(0, 0, 16'h0);
        // Drain fully plus one underflow read
        for (int i = 0; i < 9; i++) drv_a(0, 1, 16'h0);
        drv_a(0, 0, 16'h0);
        // Empty with both asserted: write only
        drv_a(1, 1, 16'hD000);
        drv_a(0, 1, 16'h0);
        drv_a(0, 0, 16'h0);
        // Fill to 4 then reset with a write pending
        for (int i = 0; i < 4; i++) drv_a(1, 0, 16'hE000 + 16'(i));
        a_if.wr_en = 1;
        do_reset(1);
        a_if.wr_en = 0;
        drv_a(0, 1, 16'h0);
        drv_a(0, 0, 16'h0);
        // Randomized traffic on A
        for (int i = 0; i < 400; i++)
            drv_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
        for (int i = 0; i < 10; i++) drv_a(0, 1, 16'h0);
        drv_a(0, 0, 16'h0);

        // B: 13 words with interleaved draining across pointer wraps
        wrote = 0;
        popped_b = 0;
        for (int c = 0; c < 60 && !(wrote == 13 && qb.size() == 0); c++) begin
            bit w;
            w = (wrote < 13) && (c % 3 != 2) && (qb.size() < 5);
            drv_b(w, (c % 2 == 1), 16'hB000 + 16'(wrote));
            if (w) wrote++;
        end
        drv_b(0, 0, 16'h0);
        @(negedge clk);
        check("b_words_out", 32'(popped_b), 32'd13);
        // Randomized traffic on B
        for (int i = 0; i < 400; i++)
            drv_b(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
        drv_b(0, 1, 16'h0);
        drv_b(0, 0, 16'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fifo_param.md
FIFO_PARAM -- requirements
Module: fifo_param

Interface
REQ-001 Parameters SHALL be:
- FIFO_WIDTH, 16, data word width in bits.
- FIFO_DEPTH, 8, word capacity; any integer >= 2, power of two not required.
- AF_THRESH, 7, almostfull threshold in words.
- AE_THRESH, 1, almostempty threshold in words.
- FWFT, 0, read mode: 0 = registered read, 1 = first-word fall-through.
REQ-002 Parameter legality SHALL be 1 <= AE_THRESH < AF_THRESH <= FIFO_DEPTH-1; an illegal set SHALL stop elaboration with an error.
REQ-003 Ports SHALL be:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- data_in  input  FIFO_WIDTH  write data.
- wr_en  input  1  write request.
- rd_en  input  1  read request.
- data_out  output  FIFO_WIDTH  read data.
- rd_valid  output  1  data_out carries a valid popped or head word.
- wr_ack  output  1  previous-cycle write accepted.
- overflow  output  1  previous-cycle write rejected.
- underflow  output  1  previous-cycle read rejected.
- full, empty, almostfull, almostempty  output  1 each  occupancy flags.
- count  output  $clog2(FIFO_DEPTH+1)  current occupancy.

Function
REQ-004 A write SHALL be accepted when wr_en=1 and count<FIFO_DEPTH, or when wr_en=1, rd_en=1 and count==FIFO_DEPTH (read frees the slot in the same cycle).
REQ-005 A read SHALL be accepted when rd_en=1 and count>0; simultaneous wr_en with count==0 SHALL NOT bypass the read.
REQ-006 wr_ack SHALL be registered, high for exactly the cycle following each accepted write; overflow SHALL be high for the cycle following each rejected write.
REQ-007 underflow SHALL be high for the cycle following each rd_en=1 when count==0, in both modes.
REQ-008 count SHALL update at the clock edge: +1 on write only, -1 on read only, unchanged on both accepted or neither.
REQ-009 Write and read pointers SHALL run 0..FIFO_DEPTH-1 and wrap from FIFO_DEPTH-1 to 0, including for non-power-of-two depths.
REQ-010 Flags SHALL be combinational from count: full = (count==FIFO_DEPTH), empty = (count==0), almostfull = (count>=AF_THRESH), almostempty = (count<=AE_THRESH) and count!=0.
REQ-011 FWFT=0: on an accepted read, data_out SHALL present the head word one cycle later with rd_valid=1 for that cycle only; data_out SHALL hold its last value otherwise.
REQ-012 FWFT=1: data_out SHALL combinationally equal the head word and rd_valid SHALL equal !empty; an accepted read advances to the next word at the edge.
REQ-013 Data order SHALL be strict FIFO with no loss, duplication or corruption across any number of wraps.

Reset
REQ-014 When rst_n=0 at a rising edge, pointers and count SHALL clear to 0; wr_ack, overflow, underflow and rd_valid (FWFT=0) SHALL clear to 0; and data_out (FWFT=0) SHALL clear to 0.
REQ-015 After that edge, empty=1, almostempty=0, full=0 and almostfull=0; in FWFT=1, rd_valid=0.
REQ-016 Storage contents SHALL NOT be cleared; reset SHALL take priority over concurrent wr_en/rd_en and discard in-flight data.

Verification
REQ-017 Defaults, FWFT=0: write 0xA001..0xA008 -> wr_ack each next cycle; count 1..8; almostfull at count 7; full at 8.
REQ-018 Full, wr_en=1 with 0xBEEF -> overflow=1 one cycle; count stays 8; later reads return 0xA001..0xA008 in order, one cycle after each rd_en.
REQ-019 Empty, rd_en=1 -> underflow=1 one cycle; rd_valid=0; count stays 0; data_out unchanged.
REQ-020 FIFO_DEPTH=5, FWFT=1: write 13 words while draining at an interleaved rate -> pointers wrap at 4->0; data_out shows the head word with no read latency; all 13 words are out in order.
REQ-021 Full, wr_en=1 and rd_en=1 same cycle -> both accepted; count stays 8; wr_ack=1; overflow=0. Empty, both asserted -> write only; underflow=1; count becomes 1.
REQ-022 Count 4, rst_n=0 for one edge with wr_en=1 -> count=0, empty=1, wr_ack=0 next cycle; a subsequent read gives underflow=1.
